// File: rtl/karatsuba_seq.sv
// karatsuba_seq: multi-cycle Karatsuba multiplier; one shared (WIDTH/2+1)-bit multiplier
// forms z2, z0 and zm on successive cycles. Define KARATSUBA_APPROX_EN to clear the low APX_BITS operand bits.
module karatsuba_seq #(
  parameter int WIDTH    = 32,
  parameter int APX_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int HALF = WIDTH / 2;
  localparam int MW   = HALF + 1;
  localparam int ZW   = 2 * HALF + 2;
  localparam int PW   = 2 * WIDTH;

  generate
    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("karatsuba_seq: WIDTH must be even and >= 4");
    end
    if (APX_BITS < 0 || APX_BITS > HALF) begin : g_bad_apx
      $error("karatsuba_seq: APX_BITS must be in 0..WIDTH/2");
    end
  endgenerate

  // IDLE wait for start | HI form z2 | LO form z0 | MID form zm | CMB combine, pulse done
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_MID  = 3'd3,
    S_CMB  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  a_cap, b_cap;
  logic [2*HALF-1:0] z2_q, z0_q;
  logic [ZW-1:0]     zm_q;
  logic [PW-1:0]     p_q, p_d;
  logic              done_q;

  logic [HALF-1:0] a_hi, a_lo, b_hi, b_lo;
  logic [MW-1:0]   sa, sb;
  logic [MW-1:0]   mul_a, mul_b;
  logic [ZW-1:0]   mul_p;
  logic [ZW-1:0]   z1;

  logic cap_en, ld_z2, ld_z0, ld_zm, ld_p;

`ifdef KARATSUBA_APPROX_EN
  localparam logic [WIDTH-1:0] APX_KEEP = ~((WIDTH'(1) << APX_BITS) - WIDTH'(1));
  assign a_cap = A & APX_KEEP;
  assign b_cap = B & APX_KEEP;
`else
  assign a_cap = A;
  assign b_cap = B;
`endif

  assign a_hi = a_q[WIDTH-1:HALF];
  assign a_lo = a_q[HALF-1:0];
  assign b_hi = b_q[WIDTH-1:HALF];
  assign b_lo = b_q[HALF-1:0];
  assign sa   = MW'(a_hi) + MW'(a_lo);
  assign sb   = MW'(b_hi) + MW'(b_lo);

  assign mul_p = ZW'(mul_a) * ZW'(mul_b);

  // zm >= z2 + z0 always, so the subtraction never wraps
  assign z1  = zm_q - ZW'(z2_q) - ZW'(z0_q);
  assign p_d = (PW'(z2_q) << WIDTH) + (PW'(z1) << HALF) + PW'(z0_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_HI;
      S_HI:    state_d = S_LO;
      S_LO:    state_d = S_MID;
      S_MID:   state_d = S_CMB;
      S_CMB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    cap_en = (state_q == S_IDLE) && start;
    ld_z2  = (state_q == S_HI);
    ld_z0  = (state_q == S_LO);
    ld_zm  = (state_q == S_MID);
    ld_p   = (state_q == S_CMB);
    mul_a  = '0;
    mul_b  = '0;
    unique case (state_q)
      S_HI: begin
        mul_a = MW'(a_hi);
        mul_b = MW'(b_hi);
      end
      S_LO: begin
        mul_a = MW'(a_lo);
        mul_b = MW'(b_lo);
      end
      S_MID: begin
        mul_a = sa;
        mul_b = sb;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      z2_q   <= '0;
      z0_q   <= '0;
      zm_q   <= '0;
      p_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= ld_p;
      if (cap_en) begin
        a_q <= a_cap;
        b_q <= b_cap;
      end
      if (ld_z2) z2_q <= mul_p[2*HALF-1:0];
      if (ld_z0) z0_q <= mul_p[2*HALF-1:0];
      if (ld_zm) zm_q <= mul_p;
      if (ld_p)  p_q  <= p_d;
    end
  end

  assign done = done_q;
  assign P    = p_q;

endmodule

// File: tb/tb_karatsuba_seq.sv
// Scoreboard bench for karatsuba_seq: three instances (16/32/64-bit) run in lockstep on a shared start.
module tb_karatsuba_seq;

  logic clk = 1'b0;
  logic rst;
  logic start;

  logic [15:0]  a16, b16;
  logic [31:0]  a32, b32;
  logic [63:0]  a64, b64;
  logic [31:0]  p16;
  logic [63:0]  p32;
  logic [127:0] p64;
  logic busy16, busy32, busy64, done16, done32, done64;

  int total = 0;
  int bad   = 0;

  logic [127:0] q16[$];
  logic [127:0] q32[$];
  logic [127:0] q64[$];

`ifdef KARATSUBA_APPROX_EN
  localparam logic [63:0] EXP_BASIC = 64'd2097664;
  localparam logic [63:0] EXP_MAX   = 64'hFFFFFFE000000100;
  localparam logic [63:0] EXP_15    = 64'd0;
  localparam logic [63:0] EXP_63    = 64'd0;
  localparam logic [63:0] EXP_143   = 64'd0;
  localparam logic [63:0] EXP_1M    = 64'd984064;
`else
  localparam logic [63:0] EXP_BASIC = 64'd2425535;
  localparam logic [63:0] EXP_MAX   = 64'hFFFFFFFE00000001;
  localparam logic [63:0] EXP_15    = 64'd15;
  localparam logic [63:0] EXP_63    = 64'd63;
  localparam logic [63:0] EXP_143   = 64'd143;
  localparam logic [63:0] EXP_1M    = 64'd1000000;
`endif

  always #5 clk = ~clk;

  karatsuba_seq #(.WIDTH(16), .APX_BITS(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .P(p16));
  karatsuba_seq #(.WIDTH(32), .APX_BITS(4)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .A(a32), .B(b32),
    .busy(busy32), .done(done32), .P(p32));
  karatsuba_seq #(.WIDTH(64), .APX_BITS(4)) u_dut64 (
    .clk(clk), .rst(rst), .start(start), .A(a64), .B(b64),
    .busy(busy64), .done(done64), .P(p64));

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] m;
    m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
`ifdef KARATSUBA_APPROX_EN
    m = m & ~64'hF;
`endif
    return 128'(a & m) * 128'(b & m);
  endfunction

  task automatic set_ops(input logic [63:0] a, input logic [63:0] b);
    a16 = a[15:0];
    b16 = b[15:0];
    a32 = a[31:0];
    b32 = b[31:0];
    a64 = a;
    b64 = b;
  endtask

  task automatic push_exp();
    q16.push_back(ref_mul(64'(a16), 64'(b16), 16));
    q32.push_back(ref_mul(64'(a32), 64'(b32), 32));
    q64.push_back(ref_mul(a64, b64, 64));
  endtask

  task automatic launch(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    set_ops(a, b);
    start = 1'b1;
    @(posedge clk);
    push_exp();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done32 !== 1'b1 && lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic drop_others();
    if (q16.size() > 0) void'(q16.pop_front());
    if (q64.size() > 0) void'(q64.pop_front());
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    set_ops(64'd0, 64'd0);
    repeat (3) begin
      @(negedge clk);
      total++;
      if (busy32 !== 1'b0 || done32 !== 1'b0 || p32 !== 64'd0) begin
        bad++;
        $display("FAIL reset_hold: busy=%b done=%b P=%0h want 0/0/0", busy32, done32, p32);
      end
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      total++;
      if (busy32 !== 1'b0 || done32 !== 1'b0 || p32 !== 64'd0 || p16 !== 32'd0 || p64 !== 128'd0) begin
        bad++;
        $display("FAIL reset_idle: busy=%b done=%b P=%0h want 0/0/0", busy32, done32, p32);
      end
    end
  endtask

  task automatic test_exact_basic();
    int lat;
    logic [127:0] e;
    logic [63:0] c [2];
    logic [63:0] ka [2];
    ka[0] = 64'd65555;      c[0] = EXP_BASIC;
    ka[1] = 64'hFFFFFFFF;   c[1] = EXP_MAX;
    for (int i = 0; i < 2; i++) begin
      launch(ka[i], (i == 0) ? 64'd37 : 64'hFFFFFFFF);
      total++;
      if (busy32 !== 1'b1) begin
        bad++;
        $display("FAIL basic_busy: busy=%b want 1", busy32);
      end
      wait_done(lat);
      total++;
      if (lat != 4) begin
        bad++;
        $display("FAIL basic_latency: got %0d want 4", lat);
      end
      e = (q32.size() > 0) ? q32.pop_front() : '1;
      drop_others();
      total++;
      if (p32 !== e[63:0] || p32 !== c[i]) begin
        bad++;
        $display("FAIL basic_product: P=%0h want %0h", p32, c[i]);
      end
      @(negedge clk);
      total++;
      if (done32 !== 1'b0 || p32 !== c[i] || busy32 !== 1'b0) begin
        bad++;
        $display("FAIL basic_after: done=%b busy=%b P=%0h want 0/0/%0h", done32, busy32, p32, c[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    int extra;
    logic [127:0] e;
    launch(64'd11, 64'd13);
    @(negedge clk);
    set_ops(64'd99, 64'd99);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    total++;
    if (lat != 2) begin
      bad++;
      $display("FAIL ignored_latency: got %0d more edges want 2", lat);
    end
    e = (q32.size() > 0) ? q32.pop_front() : '1;
    drop_others();
    total++;
    if (p32 !== e[63:0] || p32 !== EXP_143) begin
      bad++;
      $display("FAIL ignored_product: P=%0h want %0h", p32, EXP_143);
    end
    extra = 0;
    repeat (7) begin
      @(negedge clk);
      if (done32 === 1'b1 || busy32 === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ignored_no_second_op: active cycles=%0d want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    logic [127:0] e;
    @(negedge clk);
    set_ops(64'd3, 64'd5);
    start = 1'b1;
    @(posedge clk);
    push_exp();
    @(negedge clk);
    set_ops(64'd7, 64'd9);
    wait_done(lat);
    total++;
    if (lat != 4 || busy32 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first_latency: lat=%0d busy=%b want 4/0", lat, busy32);
    end
    e = (q32.size() > 0) ? q32.pop_front() : '1;
    drop_others();
    total++;
    if (p32 !== e[63:0] || p32 !== EXP_15) begin
      bad++;
      $display("FAIL b2b_first_product: P=%0h want %0h", p32, EXP_15);
    end
    @(posedge clk);
    push_exp();
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    total++;
    if (done32 !== 1'b0 || busy32 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_reaccept: done=%b busy=%b want 0/1", done32, busy32);
    end
    while (done32 !== 1'b1 && gap < 12) begin
      @(posedge clk);
      gap++;
      @(negedge clk);
    end
    total++;
    if (gap != 5) begin
      bad++;
      $display("FAIL b2b_done_spacing: got %0d want 5", gap);
    end
    e = (q32.size() > 0) ? q32.pop_front() : '1;
    drop_others();
    total++;
    if (p32 !== e[63:0] || p32 !== EXP_63) begin
      bad++;
      $display("FAIL b2b_second_product: P=%0h want %0h", p32, EXP_63);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [127:0] e;
    launch(64'd12345, 64'd678);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (p32 !== 64'd0 || busy32 !== 1'b0 || done32 !== 1'b0) begin
      bad++;
      $display("FAIL midreset_clear: P=%0h busy=%b done=%b want 0/0/0", p32, busy32, done32);
    end
    @(negedge clk);
    rst = 1'b0;
    q16.delete();
    q32.delete();
    q64.delete();
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done32 === 1'b1 || p32 !== 64'd0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midreset_no_done: bad cycles=%0d want 0", seen);
    end
    launch(64'd1000, 64'd1000);
    wait_done(lat);
    e = (q32.size() > 0) ? q32.pop_front() : '1;
    drop_others();
    total++;
    if (lat != 4 || p32 !== e[63:0] || p32 !== EXP_1M) begin
      bad++;
      $display("FAIL midreset_next: lat=%0d P=%0h want 4/%0h", lat, p32, EXP_1M);
    end
  endtask

  task automatic test_width_sweep();
    int lat;
    logic [63:0] a, b;
    logic [127:0] e16, e32, e64;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin
        a = '1;
        b = '1;
      end else if (i == 1) begin
        a = 64'd0;
        b = '1;
      end else begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
      end
      launch(a, b);
      wait_done(lat);
      total++;
      if (lat != 4 || done16 !== 1'b1 || done64 !== 1'b1) begin
        bad++;
        $display("FAIL sweep_latency[%0d]: lat=%0d d16=%b d64=%b want 4/1/1", i, lat, done16, done64);
      end
      e16 = (q16.size() > 0) ? q16.pop_front() : '1;
      e32 = (q32.size() > 0) ? q32.pop_front() : '1;
      e64 = (q64.size() > 0) ? q64.pop_front() : '1;
      total++;
      if (p16 !== e16[31:0]) begin
        bad++;
        $display("FAIL sweep16[%0d]: P=%0h want %0h", i, p16, e16[31:0]);
      end
      total++;
      if (p32 !== e32[63:0]) begin
        bad++;
        $display("FAIL sweep32[%0d]: P=%0h want %0h", i, p32, e32[63:0]);
      end
      total++;
      if (p64 !== e64) begin
        bad++;
        $display("FAIL sweep64[%0d]: P=%0h want %0h", i, p64, e64);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_exact_basic();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_width_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/karatsuba_seq.md
# karatsuba_seq

Parametrised, multi-cycle Karatsuba multiplier with a start/done handshake. It is the sequential successor to the combinational 32-bit Karatsuba multiplier. One shared (WIDTH/2+1)-bit multiplier computes the three Karatsuba partial products over successive cycles, which cuts area for wide operands. It sits behind the datapath's operand registers and feeds a registered product to downstream accumulate and compare logic.

## Interface
- WIDTH, 32: operand width in bits. Must be even and ≥ 4. HALF = WIDTH/2.
- APX_BITS, 4: number of low operand bits truncated in approximate mode. Used only when KARATSUBA_APPROX_EN is defined. Range 0..HALF.
- clk  in  1: clock, rising edge.
- rst  in  1: reset, asynchronous, active-high.
- start  in  1: request a multiply. Sampled only in IDLE.
- A  in  WIDTH: unsigned multiplicand. Captured on an accepted start.
- B  in  WIDTH: unsigned multiplier. Captured on an accepted start.
- busy  out  1: high while a multiply is in flight (state ≠ IDLE).
- done  out  1: one-cycle pulse; P is valid from this cycle onward.
- P  out  2*WIDTH: registered unsigned product. Holds its value until the next completion.

## Operation
- Operand split: AH = A[WIDTH-1:HALF], AL = A[HALF-1:0]; BH and BL likewise.
- Sums: SA = AH+AL and SB = BH+BL, each HALF+1 bits with no overflow loss.
- Partial products:
  - z2 = AH·BH
  - z0 = AL·BL
  - zm = SA·SB, 2·HALF+2 bits
  - All three come from one shared multiplier; HALF-bit inputs are zero-extended.
- Middle term: z1 = zm − z2 − z0. It is always ≥ 0, 2·HALF+2 bits, and computed without truncation.
- Result: P = (z2 << WIDTH) + (z1 << HALF) + z0, in 2·WIDTH bits. It equals A·B exactly (exact mode).
- FSM states: IDLE → HI → LO → MID → CMB → IDLE.
  - IDLE: if start=1, register A/B and go to HI. Otherwise stay.
  - HI: register z2 → LO.
  - LO: register z0 → MID.
  - MID: register zm → CMB.
  - CMB: register P, assert done for one cycle → IDLE.
- start while busy=1 is ignored; in-flight operands are unaffected.
- A/B changes after acceptance do not affect the in-flight result.
- Reset, including mid-operation:
  - state = IDLE, busy = 0, done = 0, P = 0.
  - All internal registers (z2, z0, zm, operand regs) = 0.
  - The aborted operation produces no done.

## Timing
- Edge N: start=1 in IDLE is accepted. busy=1 from the cycle after edge N.
- Edges N+1, N+2, N+3: z2, z0 and zm are registered in turn.
- Edge N+4: P is updated, done=1 and busy=0 for the cycle following N+4.
- Latency is 4 clocks from the accept edge to a valid P.
- Back-to-back: start held high is accepted again at edge N+5. Throughput is one result per 5 clocks.
- done is never high for two consecutive cycles.
- Reset values: busy=0, done=0, P=0.

## Configuration
- KARATSUBA_APPROX_EN defined:
  - On capture, the low APX_BITS bits of A and B are forced to 0 before splitting.
  - P = (A & ~mask)·(B & ~mask), where mask = 2^APX_BITS − 1.
  - Latency and handshake are unchanged.
  - APX_BITS = 0 gives exact results.
- KARATSUBA_APPROX_EN undefined:
  - The exact product is computed.
  - APX_BITS is ignored and no truncation logic is synthesised.

## Test plan
- Reset then idle: rst pulse, no start → P=0, busy=0, done=0 throughout.
- Exact basic, WIDTH=32: A=65555, B=37, start → done exactly 4 edges after accept, P=2425535. A=0xFFFFFFFF, B=0xFFFFFFFF → P=0xFFFFFFFE00000001.
- Approximate, KARATSUBA_APPROX_EN, APX_BITS=4: A=65555, B=37 → P=2097664.
- Handshake:
  - Hold start high with A=3, B=5, then change to A=7, B=9 while busy → first P=15.
  - The second accept happens at edge N+5 with P=63.
  - done pulses are exactly 5 cycles apart.
- Reset mid-operation: assert rst while in MID → P=0, no done. Next multiply A=1000, B=1000 → P=1000000.
- Width sweep: WIDTH=16 and WIDTH=64, 1000 random $urandom operand pairs each → P equals the reference A·B every time, and latency is 4 in all cases.
